// File: rtl/cmd_sequencer.sv
// Host-side command initiator for the SDRAM/DDR3 command controller: runs the reset trio,
// then bounded LOAD/RUN transfers closed with RETURN, with ack and idle timeouts.
module cmd_sequencer #(
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned IDLE_TIMEOUT = 16384,
    parameter int unsigned LEN_W        = 16
) (
    input  logic             sdramclk,
    input  logic             reset,
    input  logic             init_req,
    input  logic             load_req,
    input  logic [LEN_W-1:0] load_len,
    input  logic             run_req,
    input  logic [LEN_W-1:0] run_len,
    input  logic             wr_beat,
    input  logic             rd_beat,
    input  logic [3:0]       ctrl_state,
    output logic [3:0]       command,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             init_ok
);

    localparam int unsigned TmoW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TmoW-1:0] AckLimit  = TmoW'(ACK_TIMEOUT - 1);
    localparam logic [TmoW-1:0] IdleLimit = TmoW'(IDLE_TIMEOUT - 1);

    localparam logic [3:0] CmdNop        = 4'd0;
    localparam logic [3:0] CmdRun        = 4'd1;
    localparam logic [3:0] CmdLoad       = 4'd2;
    localparam logic [3:0] CmdResetRead  = 4'd3;
    localparam logic [3:0] CmdResetSdram = 4'd4;
    localparam logic [3:0] CmdResetWrite = 4'd5;
    localparam logic [3:0] CmdReturn     = 4'd6;

    typedef enum logic [2:0] {
        StIdle, StIssue, StAck, StWaitIdle, StXfer, StRet, StFail
    } state_e;

    state_e           state_q;
    logic [3:0]       step_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [TmoW-1:0]  tmo_q;

    logic             accept;
    logic [3:0]       req_cmd;
    logic [LEN_W-1:0] req_len;
    logic [TmoW-1:0]  tmo_inc;
    logic [LEN_W-1:0] beat_inc;
    logic             beat;
    logic             is_xfer;
    logic [3:0]       next_init_step;

    always_comb begin
        accept         = init_req | (init_ok & (load_req | run_req));
        req_cmd        = init_req ? CmdResetSdram : (load_req ? CmdLoad : CmdRun);
        req_len        = load_req ? load_len : run_len;
        tmo_inc        = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
        beat_inc       = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
        beat           = (step_q == CmdLoad) ? wr_beat : rd_beat;
        is_xfer        = (step_q == CmdLoad) || (step_q == CmdRun);
        next_init_step = (step_q == CmdResetSdram) ? CmdResetWrite : CmdResetRead;
    end

    always_ff @(posedge sdramclk) begin
        if (reset) begin
            state_q    <= StIdle;
            step_q     <= CmdNop;
            len_q      <= '0;
            beat_cnt_q <= '0;
            tmo_q      <= '0;
            command    <= CmdNop;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            init_ok    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    command <= CmdNop;
                    if (accept) begin
                        step_q  <= req_cmd;
                        len_q   <= req_len;
                        busy    <= 1'b1;
                        error   <= 1'b0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    command    <= step_q;
                    tmo_q      <= '0;
                    beat_cnt_q <= '0;
                    state_q    <= StAck;
                end
                StAck: begin
                    if (ctrl_state != 4'd0) begin
                        tmo_q <= '0;
                        if (!is_xfer) begin
                            command <= CmdNop;
                            state_q <= StWaitIdle;
                        end else if (len_q == '0) begin
                            command <= CmdReturn;
                            state_q <= StRet;
                        end else begin
                            command <= CmdNop;
                            state_q <= StXfer;
                        end
                    end else if (step_q == CmdResetRead && tmo_q != '0) begin
                        // A read-FIFO reset may complete before its state is ever visible
                        command <= CmdNop;
                        init_ok <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmo_q >= AckLimit) begin
                        command <= CmdReturn;
                        state_q <= StFail;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                StWaitIdle: begin
                    if (ctrl_state == 4'd0) begin
                        if (step_q == CmdResetRead) begin
                            init_ok <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            step_q  <= next_init_step;
                            state_q <= StIssue;
                        end
                    end else if (tmo_q >= IdleLimit) begin
                        command <= CmdReturn;
                        state_q <= StFail;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                StXfer: begin
                    if (beat) begin
                        beat_cnt_q <= beat_inc;
                        if (beat_inc == len_q) begin
                            command <= CmdReturn;
                            tmo_q   <= '0;
                            state_q <= StRet;
                        end
                    end
                end
                StRet: begin
                    if (ctrl_state == 4'd0) begin
                        command <= CmdNop;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmo_q >= AckLimit) begin
                        state_q <= StFail;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end
                StFail: begin
                    command <= CmdNop;
                    error   <= 1'b1;
                    init_ok <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: scripted controller with randomized ack/beat timing; the expected
// output timeline of every operation is derived from the command-protocol rules.
module tb_cmd_sequencer;

    logic        sdramclk = 1'b0;
    logic        reset;
    logic        init_req, load_req, run_req;
    logic [15:0] load_len, run_len;
    logic        wr_beat, rd_beat;
    logic [3:0]  ctrl_state;
    logic [3:0]  command;
    logic        busy, done, error, init_ok;

    always #5 sdramclk = ~sdramclk;

    cmd_sequencer dut (
        .sdramclk   (sdramclk),
        .reset      (reset),
        .init_req   (init_req),
        .load_req   (load_req),
        .load_len   (load_len),
        .run_req    (run_req),
        .run_len    (run_len),
        .wr_beat    (wr_beat),
        .rd_beat    (rd_beat),
        .ctrl_state (ctrl_state),
        .command    (command),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .init_ok    (init_ok)
    );

    int tests = 0;
    int fails = 0;

    // Expected outputs after the most recent edge; nx_* are sticky flags due after the next edge
    logic       chk_en = 1'b0;
    logic [3:0] exp_cmd = 4'd0;
    logic       exp_busy = 1'b0, exp_done = 1'b0;
    logic       m_error = 1'b0, m_init_ok = 1'b0;
    logic       nx_error = 1'b0, nx_init_ok = 1'b0;
    logic       beat_noise = 1'b0;

    always @(negedge sdramclk) begin
        if (chk_en) begin
            tests++;
            if (command !== exp_cmd || busy !== exp_busy || done !== exp_done ||
                error !== m_error || init_ok !== m_init_ok) begin
                fails++;
                $display("FAIL outputs @%0t: cmd/busy/done/error/init_ok got %0d/%0b/%0b/%0b/%0b required %0d/%0b/%0b/%0b/%0b",
                         $time, command, busy, done, error, init_ok,
                         exp_cmd, exp_busy, exp_done, m_error, m_init_ok);
            end
        end
    end

    // Run-length history of nonzero commands and done-pulse count, for literal checks
    logic [3:0] prev_cmd = 4'd0;
    int         run_cnt = 0;
    int         done_cnt = 0;
    int         hist_cmd[$];
    int         hist_len[$];

    always @(negedge sdramclk) begin
        if (done === 1'b1) done_cnt++;
        if (command == prev_cmd) begin
            run_cnt++;
        end else begin
            if (prev_cmd != 4'd0) begin
                hist_cmd.push_back(int'(prev_cmd));
                hist_len.push_back(run_cnt);
            end
            prev_cmd = command;
            run_cnt  = 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic clear_hist();
        hist_cmd.delete();
        hist_len.delete();
        done_cnt = 0;
    endtask

    task automatic tick(input logic [3:0] c, input logic b, input logic dn);
        @(posedge sdramclk);
        exp_cmd   = c;
        exp_busy  = b;
        exp_done  = dn;
        m_error   = nx_error;
        m_init_ok = nx_init_ok;
        #1;
        if (beat_noise) begin
            wr_beat = 1'($urandom);
            rd_beat = 1'($urandom);
        end
    endtask

    task automatic set_beats(input bit is_load, input logic own, input logic other);
        if (is_load) begin
            wr_beat = own;
            rd_beat = other;
        end else begin
            rd_beat = own;
            wr_beat = other;
        end
    endtask

    // Trio: SDRAM reset 10000, write reset 128, read reset 64 controller-busy cycles
    task automatic do_init(input logic with_load);
        logic [3:0] c;
        int d, b;
        init_req = 1'b1;
        load_req = with_load;
        load_len = 16'd5;
        nx_error = 1'b0;
        tick(4'd0, 1'b1, 1'b0);
        init_req   = 1'b0;
        load_req   = 1'b0;
        beat_noise = 1'b1;
        for (int s = 0; s < 3; s++) begin
            c = (s == 0) ? 4'd4 : ((s == 1) ? 4'd5 : 4'd3);
            d = (s == 2) ? 1 : int'($urandom_range(1, 4));
            b = (s == 0) ? 10000 : ((s == 1) ? 128 : 64);
            tick(c, 1'b1, 1'b0);
            repeat (d) tick(c, 1'b1, 1'b0);
            ctrl_state = 4'($urandom_range(1, 15));
            repeat (b) tick(4'd0, 1'b1, 1'b0);
            ctrl_state = 4'd0;
            if (s == 2) begin
                nx_init_ok = 1'b1;
                tick(4'd0, 1'b0, 1'b1);
            end else begin
                tick(4'd0, 1'b1, 1'b0);
            end
        end
        beat_noise = 1'b0;
        wr_beat    = 1'b0;
        rd_beat    = 1'b0;
        tick(4'd0, 1'b0, 1'b0);
    endtask

    // LOAD (is_load) or RUN of len beats; abort_at>0 asserts reset with that beat
    task automatic do_xfer(input bit is_load, input int len, input int abort_at);
        logic [3:0] c;
        int d, r, gap;
        c = is_load ? 4'd2 : 4'd1;
        if (is_load) begin
            load_req = 1'b1;
            load_len = 16'(len);
        end else begin
            run_req = 1'b1;
            run_len = 16'(len);
        end
        if (!nx_init_ok) begin
            tick(4'd0, 1'b0, 1'b0);
            load_req = 1'b0;
            run_req  = 1'b0;
            repeat (3) tick(4'd0, 1'b0, 1'b0);
            return;
        end
        nx_error = 1'b0;
        tick(4'd0, 1'b1, 1'b0);
        load_req = 1'b0;
        run_req  = 1'b0;
        load_len = 16'($urandom);
        run_len  = 16'($urandom);
        tick(c, 1'b1, 1'b0);
        d = int'($urandom_range(1, 4));
        repeat (d) begin
            set_beats(is_load, 1'($urandom), 1'($urandom));
            tick(c, 1'b1, 1'b0);
        end
        set_beats(is_load, 1'b0, 1'b0);
        ctrl_state = 4'($urandom_range(1, 15));
        if (len == 0) begin
            tick(4'd6, 1'b1, 1'b0);
        end else begin
            tick(4'd0, 1'b1, 1'b0);
            for (int k = 1; k <= len; k++) begin
                gap = int'($urandom_range(0, 3));
                repeat (gap) begin
                    set_beats(is_load, 1'b0, 1'($urandom));
                    init_req = ($urandom_range(0, 7) == 0);
                    tick(4'd0, 1'b1, 1'b0);
                    init_req = 1'b0;
                end
                set_beats(is_load, 1'b1, 1'($urandom));
                if (k == abort_at) begin
                    reset      = 1'b1;
                    nx_init_ok = 1'b0;
                    nx_error   = 1'b0;
                    tick(4'd0, 1'b0, 1'b0);
                    reset      = 1'b0;
                    ctrl_state = 4'd0;
                    set_beats(is_load, 1'b0, 1'b0);
                    repeat (2) tick(4'd0, 1'b0, 1'b0);
                    return;
                end
                tick((k == len) ? 4'd6 : 4'd0, 1'b1, 1'b0);
                set_beats(is_load, 1'b0, 1'b0);
            end
        end
        r = int'($urandom_range(1, 4));
        repeat (r) begin
            set_beats(is_load, 1'($urandom), 1'($urandom));
            tick(4'd6, 1'b1, 1'b0);
        end
        ctrl_state = 4'd0;
        set_beats(is_load, 1'b0, 1'b0);
        tick(4'd0, 1'b0, 1'b1);
        tick(4'd0, 1'b0, 1'b0);
    endtask

    // LOAD to a controller that never leaves IDLE
    task automatic do_fail_load();
        nx_error = 1'b0;
        load_req = 1'b1;
        load_len = 16'd4;
        tick(4'd0, 1'b1, 1'b0);
        load_req = 1'b0;
        tick(4'd2, 1'b1, 1'b0);
        repeat (15) tick(4'd2, 1'b1, 1'b0);
        tick(4'd6, 1'b1, 1'b0);
        nx_error   = 1'b1;
        nx_init_ok = 1'b0;
        tick(4'd0, 1'b0, 1'b0);
        tick(4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_hist2(input string name, input int c0, input int c1);
        chk({name, " cmd count"}, hist_cmd.size(), 2);
        if (hist_cmd.size() == 2) begin
            chk({name, " first cmd"}, hist_cmd[0], c0);
            chk({name, " second cmd"}, hist_cmd[1], c1);
        end
    endtask

    initial begin
        reset = 1'b1; init_req = 1'b0; load_req = 1'b0; run_req = 1'b0;
        load_len = 16'd0; run_len = 16'd0; wr_beat = 1'b0; rd_beat = 1'b0;
        ctrl_state = 4'd0;
        repeat (2) @(posedge sdramclk);
        #1;
        chk_en = 1'b1;
        tick(4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) tick(4'd0, 1'b0, 1'b0);

        // Transfers before init must be ignored
        do_xfer(1'b1, 8, 0);
        do_xfer(1'b0, 3, 0);

        clear_hist();
        do_init(1'b0);
        chk("trio cmd count", hist_cmd.size(), 3);
        if (hist_cmd.size() == 3) begin
            chk("trio cmd0", hist_cmd[0], 4);
            chk("trio cmd1", hist_cmd[1], 5);
            chk("trio cmd2", hist_cmd[2], 3);
            chk("read reset cmd cycles", hist_len[2], 2);
        end
        chk("trio done pulses", done_cnt, 1);
        chk("init_ok after trio", int'(init_ok), 1);

        clear_hist();
        do_xfer(1'b1, 8, 0);
        chk_hist2("load8", 2, 6);
        chk("load8 done pulses", done_cnt, 1);

        clear_hist();
        do_xfer(1'b0, 0, 0);
        chk_hist2("run0", 1, 6);

        repeat (8) do_xfer(1'($urandom), int'($urandom_range(0, 12)), 0);

        clear_hist();
        do_fail_load();
        chk_hist2("ack timeout", 2, 6);
        if (hist_len.size() == 2) begin
            chk("load cmd cycles before timeout", hist_len[0], 16);
            chk("fail return cycles", hist_len[1], 1);
        end
        chk("error after timeout", int'(error), 1);
        chk("init_ok after timeout", int'(init_ok), 0);
        chk("no done on timeout", done_cnt, 0);

        do_xfer(1'b1, 4, 0);
        do_xfer(1'b0, 2, 0);

        // init_req and load_req together: only the trio runs
        clear_hist();
        do_init(1'b1);
        chk("init+load cmd count", hist_cmd.size(), 3);
        chk("error cleared by init", int'(error), 0);
        repeat (4) tick(4'd0, 1'b0, 1'b0);

        do_xfer(1'b0, 100, 20);
        chk("init_ok after mid-run reset", int'(init_ok), 0);
        do_xfer(1'b1, 2, 0);

        do_init(1'b0);
        do_xfer(1'b1, 5, 0);
        repeat (2) do_xfer(1'($urandom), int'($urandom_range(1, 6)), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
